// File: rtl/loot_pkg.sv
// rtl/loot_pkg.sv - shared loot kinds, per-kind speed/value tables and controller states
package loot_pkg;

    typedef enum logic [1:0] {
        SMALL_GOLD = 2'd0,
        BIG_GOLD   = 2'd1,
        ROCK       = 2'd2,
        DIAMOND    = 2'd3
    } loot_kind_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_HOOKED   = 2'd1,
        ST_AWARD    = 2'd2,
        ST_COOLDOWN = 2'd3
    } claw_ctrl_state_t;

    localparam logic [3:0]  KIND_SPEED [4] = '{4'd4, 4'd2, 4'd1, 4'd8};
    localparam logic [11:0] KIND_VALUE [4] = '{12'd50, 12'd250, 12'd20, 12'd600};

    function automatic logic [15:0] idx_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/loot_priority_enc.sv
// rtl/loot_priority_enc.sv - lowest-index-wins priority encoder over the grabbable loot mask
module loot_priority_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   index
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        index = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/claw_loot_ctrl.sv
// rtl/claw_loot_ctrl.sv - grab arbitration, claw speed, score award and cooldown sequencing
module claw_loot_ctrl
    import loot_pkg::*;
#(
    parameter int         NUM_LOOTS   = 8,
    parameter logic [3:0] HOLD_FRAMES = 4'd3,
    parameter logic [3:0] BASE_SPEED  = 4'd4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   start_level,
    input  logic [NUM_LOOTS-1:0]   level_loot_mask,
    input  logic [2*NUM_LOOTS-1:0] loot_kind,
    input  logic                   claw_collision,
    input  logic [NUM_LOOTS-1:0]   loot_hit,
    input  logic                   claw_returned,
    output logic [3:0]             move_speed,
    output logic [NUM_LOOTS-1:0]   loot_alive,
    output logic [NUM_LOOTS-1:0]   loot_attached,
    output logic [11:0]            score_add,
    output logic                   score_valid,
    output logic                   all_cleared
);

    claw_ctrl_state_t     state_q;
    logic [3:0]           idx_q;
    loot_kind_t           kind_q;
    logic [3:0]           cnt_q;
    logic [3:0]           move_speed_q;
    logic [NUM_LOOTS-1:0] alive_q;
    logic [NUM_LOOTS-1:0] attached_q;
    logic [11:0]          score_add_q;
    logic                 score_valid_q;
    logic                 all_cleared_q;

    logic                 hit_valid;
    logic [3:0]           hit_index;
    loot_kind_t           hit_kind_d;

    loot_priority_enc #(.N(NUM_LOOTS)) u_enc (
        .req   (loot_hit & alive_q),
        .valid (hit_valid),
        .index (hit_index)
    );

    assign hit_kind_d = loot_kind_t'(loot_kind[{hit_index, 1'b0} +: 2]);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_EMPTY;
            idx_q         <= 4'd0;
            kind_q        <= SMALL_GOLD;
            cnt_q         <= 4'd0;
            move_speed_q  <= BASE_SPEED;
            alive_q       <= '0;
            attached_q    <= '0;
            score_add_q   <= 12'd0;
            score_valid_q <= 1'b0;
            all_cleared_q <= 1'b1;
        end else begin
            score_valid_q <= 1'b0;
            all_cleared_q <= (alive_q == '0) && (state_q == ST_EMPTY);
            // Level restart drops any carried loot without awarding it.
            if (start_level) begin
                alive_q      <= level_loot_mask;
                state_q      <= ST_EMPTY;
                attached_q   <= '0;
                cnt_q        <= 4'd0;
                move_speed_q <= BASE_SPEED;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        move_speed_q <= BASE_SPEED;
                        if (claw_collision && !claw_returned && hit_valid) begin
                            idx_q        <= hit_index;
                            kind_q       <= hit_kind_d;
                            attached_q   <= NUM_LOOTS'(idx_onehot(hit_index));
                            move_speed_q <= KIND_SPEED[hit_kind_d];
                            state_q      <= ST_HOOKED;
                        end
                    end
                    ST_HOOKED: begin
                        if (claw_returned) begin
                            state_q <= ST_AWARD;
                        end
                    end
                    ST_AWARD: begin
                        score_valid_q <= 1'b1;
                        score_add_q   <= KIND_VALUE[kind_q];
                        alive_q       <= alive_q & ~NUM_LOOTS'(idx_onehot(idx_q));
                        attached_q    <= '0;
                        move_speed_q  <= BASE_SPEED;
                        cnt_q         <= 4'd0;
                        state_q       <= (HOLD_FRAMES == 4'd0) ? ST_EMPTY : ST_COOLDOWN;
                    end
                    ST_COOLDOWN: begin
                        if (cnt_q == HOLD_FRAMES) begin
                            state_q <= ST_EMPTY;
                        end else if (startOfFrame) begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign move_speed    = move_speed_q;
    assign loot_alive    = alive_q;
    assign loot_attached = attached_q;
    assign score_add     = score_add_q;
    assign score_valid   = score_valid_q;
    assign all_cleared   = all_cleared_q;

endmodule

// File: tb/tb_claw_loot_ctrl.sv
// tb/tb_claw_loot_ctrl.sv - directed vector table, corner sequences and randomized model check
module tb_claw_loot_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        start_level = 1'b0;
    logic [7:0]  level_loot_mask = 8'h00;
    logic [15:0] loot_kind = 16'h5E55;
    logic        claw_collision = 1'b0;
    logic [7:0]  loot_hit = 8'h00;
    logic        claw_returned = 1'b0;
    logic [3:0]  move_speed;
    logic [7:0]  loot_alive;
    logic [7:0]  loot_attached;
    logic [11:0] score_add;
    logic        score_valid;
    logic        all_cleared;

    int total = 0;
    int bad = 0;

    claw_loot_ctrl #(.NUM_LOOTS(8), .HOLD_FRAMES(4'd3), .BASE_SPEED(4'd4)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .start_level     (start_level),
        .level_loot_mask (level_loot_mask),
        .loot_kind       (loot_kind),
        .claw_collision  (claw_collision),
        .loot_hit        (loot_hit),
        .claw_returned   (claw_returned),
        .move_speed      (move_speed),
        .loot_alive      (loot_alive),
        .loot_attached   (loot_attached),
        .score_add       (score_add),
        .score_valid     (score_valid),
        .all_cleared     (all_cleared)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sl;
        logic [7:0] mask;
        logic       coll;
        logic [7:0] hit;
        logic       ret;
        logic       sof;
        logic [7:0] att;
        logic [3:0] spd;
        logic       sv;
        logic [11:0] sa;
        logic [7:0] alive;
        logic       clr;
    } vec_t;

    vec_t vq[$];

    // Reference model: what the claw carries and where it is in the award/cooldown story.
    int          m_carried;
    int          m_value;
    bit          m_return_seen;
    bit          m_cooling;
    int          m_frames;
    logic [7:0]  m_alive;
    logic [3:0]  m_speed;
    logic        m_sv;
    logic [11:0] m_sa;
    logic        m_clr;
    int          spd_tab [4] = '{4, 2, 1, 8};
    int          val_tab [4] = '{50, 250, 20, 600};

    function automatic logic [33:0] pack_out(logic [7:0] att, logic [3:0] spd, logic sv,
                                             logic [11:0] sa, logic [7:0] alive, logic clr);
        return {att, spd, sv, sa, alive, clr};
    endfunction

    function automatic logic [33:0] dut_out();
        return pack_out(loot_attached, move_speed, score_valid, score_add, loot_alive, all_cleared);
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got att=%h spd=%0d sv=%b sa=%0d alive=%h clr=%b, want att=%h spd=%0d sv=%b sa=%0d alive=%h clr=%b",
                     name, act[33:26], act[25:22], act[21], act[20:9], act[8:1], act[0],
                     exp[33:26], exp[25:22], exp[21], exp[20:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_carried = -1; m_value = 0; m_return_seen = 0; m_cooling = 0; m_frames = 0;
        m_alive = 8'h00; m_speed = 4'd4; m_sv = 1'b0; m_sa = 12'd0; m_clr = 1'b1;
    endtask

    task automatic model_step();
        logic [7:0] grab;
        m_clr = (m_alive == 8'h00) && (m_carried < 0) && !m_cooling;
        m_sv = 1'b0;
        if (start_level) begin
            m_alive = level_loot_mask; m_carried = -1; m_return_seen = 0;
            m_cooling = 0; m_frames = 0; m_speed = 4'd4;
        end else if (m_return_seen) begin
            m_sv = 1'b1; m_sa = 12'(m_value);
            m_alive[m_carried] = 1'b0;
            m_carried = -1; m_return_seen = 0;
            m_cooling = 1; m_frames = 0; m_speed = 4'd4;
        end else if (m_cooling) begin
            if (m_frames == 3) m_cooling = 0;
            else if (startOfFrame) m_frames++;
        end else if (m_carried >= 0) begin
            if (claw_returned) m_return_seen = 1;
        end else begin
            m_speed = 4'd4;
            grab = loot_hit & m_alive;
            if (claw_collision && !claw_returned && grab != 8'h00) begin
                for (int i = 7; i >= 0; i--) if (grab[i]) m_carried = i;
                m_value = val_tab[loot_kind[2*m_carried +: 2]];
                m_speed = 4'(spd_tab[loot_kind[2*m_carried +: 2]]);
            end
        end
    endtask

    function automatic logic [7:0] m_att();
        return (m_carried >= 0) ? (8'h01 << m_carried) : 8'h00;
    endfunction

    task automatic drive(input logic sl, input logic [7:0] mask, input logic coll,
                         input logic [7:0] hit, input logic ret, input logic sof);
        start_level = sl; level_loot_mask = mask; claw_collision = coll;
        loot_hit = hit; claw_returned = ret; startOfFrame = sof;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          sl  mask  coll hit  ret sof   att  spd sv  sa   alive clr
        vq.push_back('{1, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 4, 0, 0,   8'hFF, 1});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 0, 0,   8'hFF, 0});
        vq.push_back('{0, 8'h00, 1, 8'h04, 0, 0, 8'h04, 2, 0, 0,   8'hFF, 0});
        vq.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 8'h04, 2, 0, 0,   8'hFF, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 8'h04, 2, 0, 0,   8'hFF, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 1, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 4, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h01, 0, 1, 8'h00, 4, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 8'h00, 4, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h30, 0, 0, 8'h10, 1, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h20, 0, 0, 8'h10, 1, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 8'h10, 1, 0, 250, 8'hFB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 1, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h04, 0, 0, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h20, 1, 0, 8'h00, 4, 0, 20,  8'hEB, 0});
        vq.push_back('{0, 8'h00, 1, 8'h20, 0, 0, 8'h20, 8, 0, 20,  8'hEB, 0});
        vq.push_back('{1, 8'h01, 0, 8'h00, 1, 0, 8'h00, 4, 0, 20,  8'h01, 0});
        vq.push_back('{0, 8'h00, 1, 8'h01, 0, 0, 8'h01, 2, 0, 20,  8'h01, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 8'h01, 2, 0, 20,  8'h01, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 1, 250, 8'h00, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 250, 8'h00, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 250, 8'h00, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 4, 0, 250, 8'h00, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 0, 250, 8'h00, 0});
        vq.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 4, 0, 250, 8'h00, 1});

        #12;
        check("reset_state", dut_out(), pack_out(8'h00, 4'd4, 1'b0, 12'd0, 8'h00, 1'b1));
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].sl, vq[i].mask, vq[i].coll, vq[i].hit, vq[i].ret, vq[i].sof);
            tick();
            check($sformatf("vec%0d", i), dut_out(),
                  pack_out(vq[i].att, vq[i].spd, vq[i].sv, vq[i].sa, vq[i].alive, vq[i].clr));
        end

        // Kind change while hooked must not alter the award.
        drive(1, 8'hFF, 0, 8'h00, 0, 0); tick();
        drive(0, 8'h00, 1, 8'h80, 0, 0); tick();
        check("grab_loot7", dut_out(), pack_out(8'h80, 4'd2, 1'b0, 12'd250, 8'hFF, 1'b0));
        loot_kind = 16'hFFFF;
        drive(0, 8'h00, 0, 8'h00, 1, 0); tick();
        drive(0, 8'h00, 0, 8'h00, 0, 0); tick();
        check("latched_kind_award", dut_out(), pack_out(8'h00, 4'd4, 1'b1, 12'd250, 8'h7F, 1'b0));
        drive(0, 8'h00, 0, 8'h00, 0, 0); tick();
        check("award_one_cycle", {33'd0, score_valid}, 34'd0);

        // Diamond grab after cooldown, then asynchronous reset while hooked.
        drive(1, 8'hFF, 0, 8'h00, 0, 0); tick();
        drive(0, 8'h00, 1, 8'h01, 0, 0); tick();
        check("grab_diamond", dut_out(), pack_out(8'h01, 4'd8, 1'b0, 12'd250, 8'hFF, 1'b0));
        drive(0, 8'h00, 0, 8'h00, 0, 0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("async_reset", dut_out(), pack_out(8'h00, 4'd4, 1'b0, 12'd0, 8'h00, 1'b1));
        @(negedge clk);
        resetN = 1'b1;

        // Randomized run against the model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            loot_kind = 16'($urandom);
            drive(($urandom_range(0, 39) == 0) || (c == 0), 8'($urandom),
                  $urandom_range(0, 3) == 0, 8'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            model_step();
            tick();
            check($sformatf("rand%0d", c), dut_out(),
                  pack_out(m_att(), m_speed, m_sv, m_sa, m_alive, m_clr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
